// File: rtl/hazard_scoreboard.sv
// Hazard unit for a deep in-order pipeline. It sits beside the DE stage and
// decides whether the DE instruction may issue. It also picks, per operand,
// which post-DE stage supplies the value, and sequences the multi-cycle
// flush after a taken branch.
module hazard_scoreboard #(
  parameter int  NUM_REGS   = 32,
  parameter int  FWD_STAGES = 2,
  parameter int  BR_PENALTY = 1,
  parameter int  CNT_W      = 32,
  localparam int REG_AW     = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              de_valid,
  input  logic [REG_AW-1:0] rs1_DE,
  input  logic [REG_AW-1:0] rs2_DE,
  input  logic              rs1_used_DE,
  input  logic              rs2_used_DE,
  input  logic [REG_AW-1:0] rd_DE,
  input  logic              rf_en_DE,
  input  logic [2:0]        lat_DE,
  input  logic              br_taken,
  output logic              de_accept,
  output logic              stall_IF,
  output logic              flush_DE,
  output logic [2:0]        forward_a,
  output logic [2:0]        forward_b,
  output logic [CNT_W-1:0]  stall_cnt
);

  // A penalty of one cycle needs no counter state at all, but keep one bit.
  localparam int              FL_W      = (BR_PENALTY > 1) ? $clog2(BR_PENALTY) : 1;
  localparam logic [FL_W-1:0] FL_RELOAD = FL_W'(BR_PENALTY - 1);
  localparam logic [2:0]      MAX_LAT   = 3'(FWD_STAGES);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              we;
  } stage_t;

  logic [2:0]       cnt_q [NUM_REGS];
  logic [2:0]       cnt_d [NUM_REGS];
  stage_t           stg_q [FWD_STAGES];
  stage_t           stg_d [FWD_STAGES];
  logic [FL_W-1:0]  flush_q, flush_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic       rs1_haz, rs2_haz, haz, flush_act, accept, stall;
  logic [2:0] lat_clamped, fwd_a, fwd_b;

  // Issue decision: a source is blocked while its producer needs more than one cycle.
  always_comb begin
    rs1_haz   = rs1_used_DE && (rs1_DE != '0) && (cnt_q[rs1_DE] > 3'd1);
    rs2_haz   = rs2_used_DE && (rs2_DE != '0) && (cnt_q[rs2_DE] > 3'd1);
    haz       = de_valid && (rs1_haz || rs2_haz);
    flush_act = br_taken || (flush_q != '0);
    accept    = de_valid && !haz && !flush_act;
    stall     = haz && !flush_act;
  end

  // Producer latency limited to what the forwarding network can cover.
  always_comb begin
    if (lat_DE == 3'd0)         lat_clamped = 3'd1;
    else if (lat_DE > MAX_LAT)  lat_clamped = MAX_LAT;
    else                        lat_clamped = lat_DE;
  end

  // Scoreboard next state: age every pending register, then let a new issue override.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = (cnt_q[r] != 3'd0) ? cnt_q[r] - 3'd1 : cnt_q[r];
    end
    if (accept && rf_en_DE && (rd_DE != '0)) begin
      cnt_d[rd_DE] = lat_clamped;
    end
  end

  // Stage pipe next state: stalled or flushed slots enter as bubbles.
  always_comb begin
    stg_d[0] = '{valid: accept, rd: rd_DE, we: rf_en_DE};
    for (int k = 1; k < FWD_STAGES; k++) begin
      stg_d[k] = stg_q[k-1];
    end
  end

  // Flush counter and stall counter next state; a new branch always reloads.
  always_comb begin
    // NOTE: every comb output gets a default first, so no path leaves it unassigned (no latch).
    flush_d     = flush_q;
    stall_cnt_d = stall_cnt_q;
    if (br_taken)              flush_d = FL_RELOAD;
    else if (flush_q != '0)    flush_d = flush_q - FL_W'(1);
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  // Operand select: scan oldest to youngest so the youngest matching producer wins.
  always_comb begin
    fwd_a = 3'd0;
    fwd_b = 3'd0;
    for (int k = FWD_STAGES - 1; k >= 0; k--) begin
      if (stg_q[k].valid && stg_q[k].we && (stg_q[k].rd == rs1_DE) && (rs1_DE != '0)) fwd_a = 3'(k + 1);
      if (stg_q[k].valid && stg_q[k].we && (stg_q[k].rd == rs2_DE) && (rs2_DE != '0)) fwd_b = 3'(k + 1);
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the scoreboard array is reset too; the first issue after reset reads it.
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= 3'd0;
      for (int k = 0; k < FWD_STAGES; k++) stg_q[k] <= '0;
      flush_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      cnt_q       <= cnt_d;
      stg_q       <= stg_d;
      flush_q     <= flush_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Outputs: forced quiet while reset is held, even though they depend on live inputs.
  always_comb begin
    de_accept = rst_n && accept;
    stall_IF  = rst_n && stall;
    flush_DE  = rst_n && (haz || flush_act);
    forward_a = rst_n ? fwd_a : 3'd0;
    forward_b = rst_n ? fwd_b : 3'd0;
    stall_cnt = stall_cnt_q;
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: a per-cycle vector table with
// hand-computed expectations, then hand sequences for mid-run reset and
// stall-counter saturation. DUT built with FWD_STAGES=2, BR_PENALTY=2, CNT_W=4.
module tb_hazard_scoreboard;

  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          de_valid;
  logic [AW-1:0] rs1_DE, rs2_DE, rd_DE;
  logic          rs1_used_DE, rs2_used_DE, rf_en_DE;
  logic [2:0]    lat_DE;
  logic          br_taken;
  logic          de_accept, stall_IF, flush_DE;
  logic [2:0]    forward_a, forward_b;
  logic [3:0]    stall_cnt;

  int checks = 0;
  int errors = 0;

  hazard_scoreboard #(
    .NUM_REGS(32), .FWD_STAGES(2), .BR_PENALTY(2), .CNT_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .de_valid(de_valid),
    .rs1_DE(rs1_DE), .rs2_DE(rs2_DE),
    .rs1_used_DE(rs1_used_DE), .rs2_used_DE(rs2_used_DE),
    .rd_DE(rd_DE), .rf_en_DE(rf_en_DE), .lat_DE(lat_DE), .br_taken(br_taken),
    .de_accept(de_accept), .stall_IF(stall_IF), .flush_DE(flush_DE),
    .forward_a(forward_a), .forward_b(forward_b), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          v;
    logic [AW-1:0] rs1;
    logic          u1;
    logic [AW-1:0] rs2;
    logic          u2;
    logic [AW-1:0] rd;
    logic          we;
    logic [2:0]    lat;
    logic          br;
    logic          acc, stl, fl;
    logic [2:0]    fa, fb;
    logic [3:0]    sc;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];

  function automatic vec_t mk(input int v, rs1, u1, rs2, u2, rd, we, lat, br,
                              acc, stl, fl, fa, fb, sc);
    vec_t t;
    t.v = 1'(v);   t.rs1 = 5'(rs1); t.u1 = 1'(u1); t.rs2 = 5'(rs2); t.u2 = 1'(u2);
    t.rd = 5'(rd); t.we = 1'(we);   t.lat = 3'(lat); t.br = 1'(br);
    t.acc = 1'(acc); t.stl = 1'(stl); t.fl = 1'(fl);
    t.fa = 3'(fa); t.fb = 3'(fb); t.sc = 4'(sc);
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    de_valid = t.v;  rs1_DE = t.rs1; rs1_used_DE = t.u1;
    rs2_DE = t.rs2;  rs2_used_DE = t.u2;
    rd_DE = t.rd;    rf_en_DE = t.we; lat_DE = t.lat; br_taken = t.br;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, " accept"}, de_accept, 0);
    check({tag, " stall"},  stall_IF,  0);
    check({tag, " flush"},  flush_DE,  0);
    check({tag, " fwd_a"},  forward_a, 0);
    check({tag, " fwd_b"},  forward_b, 0);
    check({tag, " cnt"},    stall_cnt, 0);
  endtask

  initial begin
    //            v rs1 u1 rs2 u2 rd we lat br | acc stl fl fa fb sc
    vecs[0]  = mk(1,  1, 1,  2, 1,  5, 1, 1, 0,  1, 0, 0, 0, 0, 0); // first issue after reset
    vecs[1]  = mk(1,  5, 1,  5, 1,  6, 1, 1, 0,  1, 0, 0, 1, 1, 0); // ALU chain, both from stage 1
    vecs[2]  = mk(1,  6, 1,  0, 0,  7, 1, 2, 0,  1, 0, 0, 1, 0, 0); // load x7
    vecs[3]  = mk(1,  7, 1,  5, 1,  8, 1, 1, 0,  0, 1, 1, 1, 0, 0); // load-use bubble
    vecs[4]  = mk(1,  7, 1,  5, 1,  8, 1, 1, 0,  1, 0, 0, 2, 0, 1); // retry, forward from stage 2
    vecs[5]  = mk(1,  0, 1,  0, 0,  3, 1, 1, 0,  1, 0, 0, 0, 0, 1); // write x3
    vecs[6]  = mk(1,  8, 1,  0, 0,  3, 1, 1, 0,  1, 0, 0, 2, 0, 1); // write x3 again
    vecs[7]  = mk(1,  3, 1,  3, 1,  0, 1, 2, 0,  1, 0, 0, 1, 1, 1); // youngest x3 wins; rd=x0
    vecs[8]  = mk(1,  0, 1,  0, 1,  9, 1, 2, 0,  1, 0, 0, 0, 0, 1); // x0 never forwarded
    vecs[9]  = mk(1,  9, 1,  0, 0, 10, 1, 1, 1,  0, 0, 1, 1, 0, 1); // branch over load-use
    vecs[10] = mk(1,  9, 1,  0, 0, 10, 1, 1, 0,  0, 0, 1, 2, 0, 1); // second flush cycle
    vecs[11] = mk(1, 10, 1,  9, 1, 11, 1, 2, 0,  1, 0, 0, 0, 0, 1); // flushed op left no trace
    vecs[12] = mk(0, 11, 1,  0, 0,  0, 0, 0, 1,  0, 0, 1, 1, 0, 1); // branch with empty DE
    vecs[13] = mk(1, 11, 1,  0, 0, 12, 1, 1, 1,  0, 0, 1, 2, 0, 1); // branch reloads flush
    vecs[14] = mk(1, 11, 1,  0, 0, 12, 1, 1, 0,  0, 0, 1, 0, 0, 1); // reloaded tail
    vecs[15] = mk(1, 11, 1,  0, 0, 12, 1, 1, 0,  1, 0, 0, 0, 0, 1); // flush over
    vecs[16] = mk(1, 12, 1,  0, 0, 13, 1, 0, 0,  1, 0, 0, 1, 0, 1); // lat 0 treated as 1
    vecs[17] = mk(1, 13, 1,  0, 0, 14, 1, 7, 0,  1, 0, 0, 1, 0, 1); // lat 7 clamped to 2
    vecs[18] = mk(1, 14, 1,  0, 0, 15, 0, 1, 0,  0, 1, 1, 1, 0, 1); // exactly one bubble
    vecs[19] = mk(1, 14, 1,  0, 0, 15, 0, 1, 0,  1, 0, 0, 2, 0, 2);
    vecs[20] = mk(1, 15, 1, 16, 0, 16, 1, 2, 0,  1, 0, 0, 0, 0, 2); // non-writer not forwarded
    vecs[21] = mk(1,  0, 0, 16, 0,  0, 0, 1, 0,  1, 0, 0, 0, 1, 2); // unused src: no stall, still fwd
    vecs[22] = mk(1, 16, 1,  0, 0,  0, 0, 1, 0,  1, 0, 0, 2, 0, 2);

    // Reset held with random inputs: every output must stay 0.
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      de_valid = 1'($urandom); rs1_DE = 5'($urandom); rs2_DE = 5'($urandom);
      rs1_used_DE = 1'($urandom); rs2_used_DE = 1'($urandom);
      rd_DE = 5'($urandom); rf_en_DE = 1'($urandom); lat_DE = 3'($urandom);
      br_taken = 1'($urandom);
      @(negedge clk);
      check_quiet($sformatf("reset%0d", i));
    end
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1 rst_n = 1'b1;

    // Table-driven cycle sequence.
    for (int i = 0; i < NV; i++) begin
      @(posedge clk); #1;
      drive(vecs[i]);
      @(negedge clk);
      check($sformatf("v%0d accept", i), de_accept, vecs[i].acc);
      check($sformatf("v%0d stall",  i), stall_IF,  vecs[i].stl);
      check($sformatf("v%0d flush",  i), flush_DE,  vecs[i].fl);
      check($sformatf("v%0d fwd_a",  i), forward_a, vecs[i].fa);
      check($sformatf("v%0d fwd_b",  i), forward_b, vecs[i].fb);
      check($sformatf("v%0d cnt",    i), stall_cnt, vecs[i].sc);
    end

    // Reset in the middle of a load-use stall clears everything at once.
    @(posedge clk); #1;
    drive(mk(1, 0, 0, 0, 0, 20, 1, 2, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    check("mid load accept", de_accept, 1);
    @(posedge clk); #1;
    drive(mk(1, 20, 1, 0, 0, 21, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    check("mid use stall", stall_IF, 1);
    check("mid use fwd_a", forward_a, 1);
    check("mid use cnt", stall_cnt, 2);
    #2 rst_n = 1'b0; br_taken = 1'b1;
    #1 check_quiet("midreset");
    br_taken = 1'b0;
    rst_n = 1'b1;
    #1;
    check("post reset accept", de_accept, 1);
    check("post reset stall",  stall_IF,  0);
    check("post reset fwd_a",  forward_a, 0);
    check("post reset cnt",    stall_cnt, 0);

    // Self-dependent load: stalls every other cycle; counter must saturate at 15.
    drive(mk(1, 7, 1, 0, 0, 7, 1, 2, 0, 0, 0, 0, 0, 0, 0));
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("sat cnt after 20", stall_cnt, 10);
    repeat (30) @(posedge clk);
    @(negedge clk);
    check("sat cnt after 50", stall_cnt, 15);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("sat cnt held", stall_cnt, 15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
